// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
//
// Purpose: bundles the fetch controller's bus into one interface. It carries the
// hazard/redirect controls, the instruction-ROM address/data pair and the IF/ID
// pipeline register outputs.
//
// Signals (named from the fetch controller's point of view):
//   stall_i      hazard unit: hold PC and IF/ID
//   redirect_i   ID-stage branch taken or jump
//   target_i     redirect target byte address
//   flush_i      load a NOP into IF/ID
//   im_instr_i   ROM data, combinational from im_addr_o
//   im_addr_o    byte address to ROM (the fetch PC)
//   instr_d_o    IF/ID instruction
//   pc_d_o       IF/ID PC
//   pc8_d_o      IF/ID PC+8 (link value)
//   halted_o     fetch halted by the bounds checker
//   fetch_cnt_o  count of words latched into IF/ID
//
// Modports:
//   slave   the fetch controller
//   master  whatever drives the controls and supplies ROM data (core or bench)
// -----------------------------------------------------------------------------
interface fetch_ctrl_if;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] target_i;
  logic        flush_i;
  logic [31:0] im_instr_i;
  logic [31:0] im_addr_o;
  logic [31:0] instr_d_o;
  logic [31:0] pc_d_o;
  logic [31:0] pc8_d_o;
  logic        halted_o;
  logic [31:0] fetch_cnt_o;

  modport slave (
    input  stall_i, redirect_i, target_i, flush_i, im_instr_i,
    output im_addr_o, instr_d_o, pc_d_o, pc8_d_o, halted_o, fetch_cnt_o
  );

  modport master (
    output stall_i, redirect_i, target_i, flush_i, im_instr_i,
    input  im_addr_o, instr_d_o, pc_d_o, pc8_d_o, halted_o, fetch_cnt_o
  );
endinterface : fetch_ctrl_if

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Purpose: instruction-fetch controller for the pipelined MIPS core. It owns the
// fetch-stage PC (pc_f) and drives it straight onto the address of the
// combinational instruction ROM. It applies stall, branch/jump redirect with
// delay-slot semantics, and flush. It also registers the fetched word into the
// IF/ID pipeline register.
//
// Optional feature: define FETCH_BOUNDS_CHECK_EN to enable the bounds checker.
// The checker halts fetch when pc_f leaves [RESET_PC, RESET_PC+4*IM_WORDS) or
// is not word aligned. Once halted, fetch stays halted until reset. Without the
// macro, halted_o is tied low and redirect targets are forced word aligned.
//
// Parameters:
//   RESET_PC   PC after reset; also the ROM base address
//   IM_WORDS   ROM depth in 32-bit words
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    fetch_ctrl_if.slave (controls in, ROM address/data, IF/ID outputs)
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 32768
) (
  input logic         clk,
  input logic         reset,
  fetch_ctrl_if.slave bus
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e      state_q, state_d;

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc8_q, ifid_pc8_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  logic [31:0] target_eff;
  logic        fault;
  logic        run;
  logic        halted;

  // Both sums wrap modulo 2^32: 0xFFFF_FFFC + 4 gives 0.
  assign pc_plus4 = pc_f_q + 32'd4;
  assign pc_plus8 = pc_f_q + 32'd8;

`ifdef FETCH_BOUNDS_CHECK_EN
  // The range compare uses 33 bits so that a window ending at 2^32 cannot wrap.
  localparam logic [32:0] PC_LO = {1'b0, RESET_PC};
  localparam logic [32:0] PC_HI = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

  logic [32:0] pc_wide;
  assign pc_wide = {1'b0, pc_f_q};

  // The target's low bits are kept. A misaligned target then faults on the
  // cycle after it reaches pc_f, instead of being silently realigned.
  assign target_eff = bus.target_i;

  // A fault is only raised when the word would actually be latched, so a
  // stalled bad PC waits until the stall releases.
  assign fault = (state_q == ST_RUN) && !bus.stall_i &&
                 ((pc_wide < PC_LO) || (pc_wide >= PC_HI) ||
                  (pc_f_q[1:0] != 2'b00));
`else
  assign target_eff = bus.target_i & 32'hFFFF_FFFC;
  assign fault      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments so every register
  // samples its _d value from before the edge, whatever the process order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before any branch. This
  // prevents a path that leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:  if (fault) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;         // only reset leaves HALT
      default: state_d = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    run = (state_q == ST_RUN);
`ifdef FETCH_BOUNDS_CHECK_EN
    halted = (state_q == ST_HALT);
`else
    halted = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state: PC selection and IF/ID update
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_f_d       = pc_f_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc8_d   = ifid_pc8_q;
    fetch_cnt_d  = fetch_cnt_q;

    if (run) begin
      if (fault) begin
        // The faulting word is replaced by a NOP. PC, the IF/ID PCs and the
        // counter freeze from here until reset.
        ifid_instr_d = 32'h0000_0000;
      end else begin
        // PC: stall > redirect > sequential. A redirect seen during a stall
        // is dropped; the branch is still in ID and will re-assert it.
        if (!bus.stall_i) begin
          pc_f_d = bus.redirect_i ? target_eff : pc_plus4;
        end

        // IF/ID: flush > stall > load. A flush leaves PC selection alone.
        // The word fetched in the redirect cycle is the delay slot and is
        // latched like any other word.
        if (bus.flush_i) begin
          ifid_instr_d = 32'h0000_0000;
          ifid_pc_d    = pc_f_q;
          ifid_pc8_d   = pc_plus8;
        end else if (!bus.stall_i) begin
          ifid_instr_d = bus.im_instr_i;
          ifid_pc_d    = pc_f_q;
          ifid_pc8_d   = pc_plus8;
          fetch_cnt_d  = fetch_cnt_q + 32'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: every register here is a pipeline/control flop that software-visible
  // behaviour depends on, so all of them take the async reset. There is no
  // storage array here that could be left unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f_q       <= RESET_PC;
      ifid_instr_q <= 32'h0000_0000;
      ifid_pc_q    <= 32'h0000_0000;
      ifid_pc8_q   <= 32'h0000_0000;
      fetch_cnt_q  <= 32'h0000_0000;
    end else begin
      pc_f_q       <= pc_f_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc8_q   <= ifid_pc8_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.im_addr_o   = pc_f_q;
  assign bus.instr_d_o   = ifid_instr_q;
  assign bus.pc_d_o      = ifid_pc_q;
  assign bus.pc8_d_o     = ifid_pc8_q;
  assign bus.halted_o    = halted;
  assign bus.fetch_cnt_o = fetch_cnt_q;

endmodule : fetch_ctrl
